avalon_hex_writer_master_de1soc: RTL

Avalon-MM write master that drives the DE1-SoC hex-display register slave. It accepts a packed hex value of NUM_SEGMENT nibbles over a valid/ready handshake. It then issues one single-word Avalon write per digit, each to word address k with byteenable 4'b0001, honouring waitrequest. A shadow copy of the last digits written lets it skip writes for unchanged digits, so display refreshes cost bus cycles only for the digits that differ.

---
 rtl/avalon_hex_writer_master_de1soc_if.sv | 24 ++
 rtl/avalon_hex_writer_master_de1soc.sv | 138 +++++++++++++
 2 files changed

// File: rtl/avalon_hex_writer_master_de1soc_if.sv
// rtl/avalon_hex_writer_master_de1soc_if.sv - Avalon-MM write bus between the hex writer master and the display slave
interface avalon_hex_writer_master_de1soc_if;
  logic [2:0]  avm_address_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_write_o;
  logic [31:0] avm_writedata_o;
  logic        avm_waitrequest_i;

  modport master (
    output avm_address_o,
    output avm_byteenable_o,
    output avm_write_o,
    output avm_writedata_o,
    input  avm_waitrequest_i
  );

  modport slave (
    input  avm_address_o,
    input  avm_byteenable_o,
    input  avm_write_o,
    input  avm_writedata_o,
    output avm_waitrequest_i
  );
endinterface

// File: rtl/avalon_hex_writer_master_de1soc.sv
// rtl/avalon_hex_writer_master_de1soc.sv - Avalon-MM master writing changed hex digits to the DE1-SoC display slave
module avalon_hex_writer_master_de1soc #(
  parameter int NUM_SEGMENT = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SEGMENT*4-1:0]   value_i,
  input  logic                       force_i,
  input  logic                       value_valid_i,
  output logic                       value_ready_o,
  avalon_hex_writer_master_de1soc_if.master avm,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_SEGMENT - 1);

  state_t                     state_q;
  state_t                     state_d;
  logic [2:0]                 idx_q;
  logic [NUM_SEGMENT*4-1:0]   val_q;
  logic                       force_q;
  logic [NUM_SEGMENT*4-1:0]   shadow_q;
  logic                       shadow_valid_q;

  logic [3:0]                 cur_digit;
  logic [3:0]                 shadow_digit;
  logic                       need_write;
  logic                       is_last;
  logic                       write_done;

  // Select the current digit and its shadow copy by the digit index
  always_comb begin
    cur_digit    = 4'd0;
    shadow_digit = 4'd0;
    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (idx_q == 3'(k)) begin
        cur_digit    = val_q[4*k +: 4];
        shadow_digit = shadow_q[4*k +: 4];
      end
    end
  end

  assign is_last    = (idx_q == LAST_IDX);
  assign need_write = force_q | ~shadow_valid_q | (cur_digit != shadow_digit);
  assign write_done = (state_q == S_WRITE) & ~avm.avm_waitrequest_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (value_valid_i) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (need_write)   state_d = S_WRITE;
        else if (is_last) state_d = S_DONE;
        else              state_d = S_CHECK;
      end
      S_WRITE: begin
        if (write_done) state_d = is_last ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state so waitrequest never reaches an output combinationally
  always_comb begin
    value_ready_o        = (state_q == S_IDLE);
    busy_o               = (state_q != S_IDLE);
    done_o               = (state_q == S_DONE);
    avm.avm_write_o      = (state_q == S_WRITE);
    avm.avm_address_o    = 3'd0;
    avm.avm_byteenable_o = 4'b0000;
    avm.avm_writedata_o  = 32'd0;
    if (state_q == S_WRITE) begin
      avm.avm_address_o    = idx_q;
      avm.avm_byteenable_o = 4'b0001;
      avm.avm_writedata_o  = {28'd0, cur_digit};
    end
  end

  // Datapath: captured value, digit index and the shadow of digits already on the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q          <= 3'd0;
      val_q          <= '0;
      force_q        <= 1'b0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (value_valid_i) begin
            val_q   <= value_i;
            force_q <= force_i;
            idx_q   <= 3'd0;
          end
        end
        S_CHECK: begin
          if (!need_write && !is_last) idx_q <= idx_q + 3'd1;
        end
        S_WRITE: begin
          if (write_done) begin
            for (int k = 0; k < NUM_SEGMENT; k++) begin
              if (idx_q == 3'(k)) shadow_q[4*k +: 4] <= cur_digit;
            end
            if (!is_last) idx_q <= idx_q + 3'd1;
          end
        end
        S_DONE: begin
          shadow_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
